ysyx_22050598_csr_trap: RTL

Parametrised machine-mode CSR file with trap sequencing for the ysyx_22050598 core, sitting beside the EX stage. Executes all six Zicsr ops on an expanded CSR set and takes ecall, mret, illegal-CSR and machine-timer-interrupt traps. Hands the fetch stage a registered PC redirect over a valid/ready handshake. Adds MIE/MPIE stacking, vectored mtvec and free-running counters.

---
 rtl/ysyx_22050598_csr_trap_pkg.sv | 50 +++++
 rtl/ysyx_22050598_csr_trap_ctrl.sv | 106 ++++++++++
 rtl/ysyx_22050598_dfflr.sv | 47 ++++
 rtl/ysyx_22050598_csr_trap.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050598_csr_trap_pkg.sv
// rtl/ysyx_22050598_csr_trap_pkg.sv - shared constants for the machine-mode CSR/trap block
// Holds CSR addresses, mstatus bit indices, cause codes, op one-hot positions,
// default reset values and the redirect FSM state type.
package ysyx_22050598_csr_trap_pkg;

    // Implemented CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // mstatus fields
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mie / mip timer bit
    localparam int MIX_MT = 7;

    // Exception / interrupt codes; CAUSE_INTERRUPT is placed in the mcause MSB
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_MTI       = 4'd7;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;
    localparam logic       CAUSE_INTERRUPT = 1'b1;

    // One-hot op bit positions in ex_csr_bus_i
    localparam int OP_CSRRW  = 5;
    localparam int OP_CSRRS  = 4;
    localparam int OP_CSRRC  = 3;
    localparam int OP_CSRRWI = 2;
    localparam int OP_CSRRSI = 1;
    localparam int OP_CSRRCI = 0;

    // Default reset values
    localparam logic [63:0] MSTATUS_RESETVAL_DEF = 64'h0000_000a_0000_1800;
    localparam logic [63:0] MTVEC_RESETVAL_DEF   = 64'h0;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } redirect_state_e;

endpackage

// File: rtl/ysyx_22050598_csr_trap_ctrl.sv
// rtl/ysyx_22050598_csr_trap_ctrl.sv - trap priority, target PC and IDLE/REDIRECT FSM
// Inputs: EX valid, decoded illegal/ecall/mret/write-intent, MIE/MTIE/mtip, mtvec, mepc,
//         redirect_ready. Outputs: ex_ready, trap/mret/csr-commit strobes, trap cause,
//         registered redirect valid/pc.
module ysyx_22050598_csr_trap_ctrl
    import ysyx_22050598_csr_trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ex_valid,
    input  logic            i_illegal,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic            i_wr_intent,
    input  logic            i_mstatus_mie,
    input  logic            i_mie_mtie,
    input  logic            i_mtip,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_redirect_ready,
    output logic            o_ex_ready,
    output logic            o_trap_take,
    output logic            o_mret_take,
    output logic            o_csr_commit,
    output logic [XLEN-1:0] o_trap_cause,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);
    redirect_state_e r_state;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_hs;
    logic            w_take_intr;
    logic            w_take_ill;
    logic            w_take_ecall;
    logic            w_take_mret;
    logic            w_take_any;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_vec_off;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_cause;

    assign o_ex_ready = (r_state == ST_IDLE);
    assign w_hs       = i_ex_valid & o_ex_ready;

    // Priority chain: interrupt > illegal > ecall > mret > CSR op
    assign w_take_intr  = w_hs & i_mstatus_mie & i_mie_mtie & i_mtip;
    assign w_take_ill   = w_hs & ~w_take_intr & i_illegal;
    assign w_take_ecall = w_hs & ~w_take_intr & ~i_illegal & i_ecall;
    assign w_take_mret  = w_hs & ~w_take_intr & ~i_illegal & ~i_ecall & i_mret;
    assign o_csr_commit = w_hs & ~w_take_intr & ~i_illegal & ~i_ecall & ~i_mret & i_wr_intent;

    assign o_trap_take = w_take_intr | w_take_ill | w_take_ecall;
    assign o_mret_take = w_take_mret;
    assign w_take_any  = o_trap_take | w_take_mret;

    always_comb begin
        w_cause = XLEN'(CAUSE_ECALL);
        if (w_take_intr) begin
            w_cause            = XLEN'(CAUSE_MTI);
            w_cause[XLEN-1]    = CAUSE_INTERRUPT;
        end else if (w_take_ill) begin
            w_cause            = XLEN'(CAUSE_ILLEGAL);
        end
    end
    assign o_trap_cause = w_cause;

    // Vectored mode only offsets interrupts; exceptions always land on the base
    assign w_trap_base = {i_mtvec[XLEN-1:2], 2'b00};
    assign w_vec_off   = (w_take_intr && (i_mtvec[1:0] == 2'b01)) ? XLEN'({CAUSE_MTI, 2'b00}) : '0;
    assign w_target    = w_take_mret ? i_mepc : (w_trap_base + w_vec_off);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_any) begin
                        r_state          <= ST_REDIRECT;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_target;
                    end
                end
                ST_REDIRECT: begin
                    if (i_redirect_ready) begin
                        r_state          <= ST_IDLE;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
endmodule

// File: rtl/ysyx_22050598_dfflr.sv
// rtl/ysyx_22050598_dfflr.sv - load-enable flop cells with asynchronous active-low reset
// ysyx_22050598_dfflr: resets to zero. ysyx_22050598_dfflr_with_resetval: resets to RESETVAL.
// Ports: clk, rst (active-low), i_lden (load enable), i_dnxt (next value), o_qout (state).
module ysyx_22050598_dfflr #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);
    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_lden) begin
            r_q <= i_dnxt;
        end
    end

    assign o_qout = r_q;
endmodule

module ysyx_22050598_dfflr_with_resetval #(
    parameter int            DW       = 64,
    parameter logic [DW-1:0] RESETVAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);
    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESETVAL;
        end else if (i_lden) begin
            r_q <= i_dnxt;
        end
    end

    assign o_qout = r_q;
endmodule

// File: rtl/ysyx_22050598_csr_trap.sv
// rtl/ysyx_22050598_csr_trap.sv - machine-mode CSR file with trap sequencing beside EX
// Ports: EX handshake (ex_valid_i/ex_ready_o), instruction info (pc, csr bus/addr/rs1/zimm,
//        ecall/mret), mtip_i, combinational csr_rd_data_o, registered redirect valid/ready/pc.
// Build option: YSYX_22050598_CSR_COUNTERS_EN enables mcycle/minstret; otherwise both read 0.
module ysyx_22050598_csr_trap
    import ysyx_22050598_csr_trap_pkg::*;
#(
    parameter int              XLEN             = 64,
    parameter logic [XLEN-1:0] MSTATUS_RESETVAL = XLEN'(MSTATUS_RESETVAL_DEF),
    parameter logic [XLEN-1:0] MTVEC_RESETVAL   = XLEN'(MTVEC_RESETVAL_DEF),
    parameter logic [XLEN-1:0] HART_ID          = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [5:0]      ex_csr_bus_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_rs1_i,
    input  logic [4:0]      csr_zimm_i,
    input  logic            csr_src_zero_i,
    input  logic            ex_inst_is_ecall_i,
    input  logic            ex_inst_is_mret_i,
    input  logic            mtip_i,
    output logic [XLEN-1:0] csr_rd_data_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i
);
    logic            w_csr_op, w_op_rw, w_op_rs, w_op_imm, w_wr_intent;
    logic [XLEN-1:0] w_src, w_old, w_wdata, w_mip, w_mcycle, w_minstret;
    logic            w_addr_hit, w_addr_ro, w_illegal;
    logic            w_trap_take, w_mret_take, w_csr_commit;
    logic [XLEN-1:0] w_trap_cause;

    logic [XLEN-1:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic [XLEN-1:0] w_mstatus_nxt, w_mepc_nxt, w_mcause_nxt;
    logic            w_mstatus_en, w_mepc_en, w_mcause_en;
    logic            w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause;

    // Op decode; the rc variants fall out as "neither rw nor rs"
    assign w_csr_op    = |ex_csr_bus_i;
    assign w_op_rw     = ex_csr_bus_i[OP_CSRRW] | ex_csr_bus_i[OP_CSRRWI];
    assign w_op_rs     = ex_csr_bus_i[OP_CSRRS] | ex_csr_bus_i[OP_CSRRSI];
    assign w_op_imm    = ex_csr_bus_i[OP_CSRRWI] | ex_csr_bus_i[OP_CSRRSI] | ex_csr_bus_i[OP_CSRRCI];
    assign w_src       = w_op_imm ? {{(XLEN-5){1'b0}}, csr_zimm_i} : csr_rs1_i;
    // rs/rc with a zero source are pure reads, which keeps them legal on read-only CSRs
    assign w_wr_intent = w_csr_op & (w_op_rw | ~csr_src_zero_i);

    assign w_mip = {{(XLEN-MIX_MT-1){1'b0}}, mtip_i, {MIX_MT{1'b0}}};

    always_comb begin
        w_old      = '0;
        w_addr_hit = 1'b1;
        w_addr_ro  = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS:  w_old = r_mstatus;
            CSR_MIE:      w_old = r_mie;
            CSR_MTVEC:    w_old = r_mtvec;
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MEPC:     w_old = r_mepc;
            CSR_MCAUSE:   w_old = r_mcause;
            CSR_MIP:      begin w_old = w_mip;   w_addr_ro = 1'b1; end
            CSR_MCYCLE:   w_old = w_mcycle;
            CSR_MINSTRET: w_old = w_minstret;
            CSR_MHARTID:  begin w_old = HART_ID; w_addr_ro = 1'b1; end
            default:      w_addr_hit = 1'b0;
        endcase
    end

    assign w_illegal     = w_csr_op & (~w_addr_hit | (w_addr_ro & w_wr_intent));
    assign csr_rd_data_o = (w_csr_op & ~w_illegal) ? w_old : '0;
    assign w_wdata       = w_op_rw ? w_src : (w_op_rs ? (w_old | w_src) : (w_old & ~w_src));

    ysyx_22050598_csr_trap_ctrl #(.XLEN(XLEN)) u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .i_ex_valid       (ex_valid_i),
        .i_illegal        (w_illegal),
        .i_ecall          (ex_inst_is_ecall_i),
        .i_mret           (ex_inst_is_mret_i),
        .i_wr_intent      (w_wr_intent),
        .i_mstatus_mie    (r_mstatus[MSTATUS_MIE]),
        .i_mie_mtie       (r_mie[MIX_MT]),
        .i_mtip           (mtip_i),
        .i_mtvec          (r_mtvec),
        .i_mepc           (r_mepc),
        .i_redirect_ready (redirect_ready_i),
        .o_ex_ready       (ex_ready_o),
        .o_trap_take      (w_trap_take),
        .o_mret_take      (w_mret_take),
        .o_csr_commit     (w_csr_commit),
        .o_trap_cause     (w_trap_cause),
        .o_redirect_valid (redirect_valid_o),
        .o_redirect_pc    (redirect_pc_o)
    );

    assign w_wr_mstatus  = w_csr_commit & (csr_addr_i == CSR_MSTATUS);
    assign w_wr_mie      = w_csr_commit & (csr_addr_i == CSR_MIE);
    assign w_wr_mtvec    = w_csr_commit & (csr_addr_i == CSR_MTVEC);
    assign w_wr_mscratch = w_csr_commit & (csr_addr_i == CSR_MSCRATCH);
    assign w_wr_mepc     = w_csr_commit & (csr_addr_i == CSR_MEPC);
    assign w_wr_mcause   = w_csr_commit & (csr_addr_i == CSR_MCAUSE);

    // Trap entry / mret stack the interrupt enable; a commit never coincides with either
    always_comb begin
        w_mstatus_nxt = r_mstatus;
        if (w_trap_take) begin
            w_mstatus_nxt[MSTATUS_MPIE]                  = r_mstatus[MSTATUS_MIE];
            w_mstatus_nxt[MSTATUS_MIE]                   = 1'b0;
            w_mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (w_mret_take) begin
            w_mstatus_nxt[MSTATUS_MIE]                   = r_mstatus[MSTATUS_MPIE];
            w_mstatus_nxt[MSTATUS_MPIE]                  = 1'b1;
            w_mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (w_wr_mstatus) begin
            w_mstatus_nxt = w_wdata;
        end
    end
    assign w_mstatus_en = w_trap_take | w_mret_take | w_wr_mstatus;

    assign w_mepc_nxt   = w_trap_take ? ex_pc_i : w_wdata;
    assign w_mepc_en    = w_trap_take | w_wr_mepc;
    assign w_mcause_nxt = w_trap_take ? w_trap_cause : w_wdata;
    assign w_mcause_en  = w_trap_take | w_wr_mcause;

    ysyx_22050598_dfflr_with_resetval #(.DW(XLEN), .RESETVAL(MSTATUS_RESETVAL)) u_mstatus (
        .clk(clk), .rst(rst), .i_lden(w_mstatus_en), .i_dnxt(w_mstatus_nxt), .o_qout(r_mstatus));
    ysyx_22050598_dfflr_with_resetval #(.DW(XLEN), .RESETVAL(MTVEC_RESETVAL)) u_mtvec (
        .clk(clk), .rst(rst), .i_lden(w_wr_mtvec), .i_dnxt(w_wdata), .o_qout(r_mtvec));
    ysyx_22050598_dfflr #(.DW(XLEN)) u_mie (
        .clk(clk), .rst(rst), .i_lden(w_wr_mie), .i_dnxt(w_wdata), .o_qout(r_mie));
    ysyx_22050598_dfflr #(.DW(XLEN)) u_mscratch (
        .clk(clk), .rst(rst), .i_lden(w_wr_mscratch), .i_dnxt(w_wdata), .o_qout(r_mscratch));
    ysyx_22050598_dfflr #(.DW(XLEN)) u_mepc (
        .clk(clk), .rst(rst), .i_lden(w_mepc_en), .i_dnxt(w_mepc_nxt), .o_qout(r_mepc));
    ysyx_22050598_dfflr #(.DW(XLEN)) u_mcause (
        .clk(clk), .rst(rst), .i_lden(w_mcause_en), .i_dnxt(w_mcause_nxt), .o_qout(r_mcause));

`ifdef YSYX_22050598_CSR_COUNTERS_EN
    logic [XLEN-1:0] r_mcycle, r_minstret, w_mcycle_nxt, w_minstret_nxt;
    logic            w_wr_mcycle, w_wr_minstret, w_retire;

    assign w_wr_mcycle    = w_csr_commit & (csr_addr_i == CSR_MCYCLE);
    assign w_wr_minstret  = w_csr_commit & (csr_addr_i == CSR_MINSTRET);
    assign w_retire       = ex_valid_i & ex_ready_o & ~w_trap_take;
    // A software write in the same cycle overrides the increment
    assign w_mcycle_nxt   = w_wr_mcycle   ? w_wdata : (r_mcycle + XLEN'(1));
    assign w_minstret_nxt = w_wr_minstret ? w_wdata : (r_minstret + XLEN'(1));

    ysyx_22050598_dfflr #(.DW(XLEN)) u_mcycle (
        .clk(clk), .rst(rst), .i_lden(1'b1), .i_dnxt(w_mcycle_nxt), .o_qout(r_mcycle));
    ysyx_22050598_dfflr #(.DW(XLEN)) u_minstret (
        .clk(clk), .rst(rst), .i_lden(w_wr_minstret | w_retire), .i_dnxt(w_minstret_nxt),
        .o_qout(r_minstret));

    assign w_mcycle   = r_mcycle;
    assign w_minstret = r_minstret;
`else
    assign w_mcycle   = '0;
    assign w_minstret = '0;
`endif

endmodule
